// File: rtl/spi_mst.sv
// SPI master (mode 0, MSB first) for the on-chip register slave: sends one 24-bit
// {wr,addr,data,crc} frame per request and returns the CRC-checked response of the prior frame.
module spi_mst #(
  parameter int unsigned REG_AW    = 7,
  parameter int unsigned REG_DW    = 8,
  parameter int unsigned REG_CRC_W = 8,
  parameter int unsigned SCLK_DIV  = 2,
  parameter int unsigned CS_SETUP  = 2,
  parameter int unsigned CS_HOLD   = 2,
  parameter int unsigned GAP_CYC   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_mst_en,
  input  logic              i_req_vld,
  output logic              o_req_rdy,
  input  logic              i_req_wr,
  input  logic [REG_AW-1:0] i_req_addr,
  input  logic [REG_DW-1:0] i_req_wdata,
  output logic              o_rsp_vld,
  output logic              o_rsp_flag,
  output logic [REG_AW-1:0] o_rsp_addr,
  output logic [REG_DW-1:0] o_rsp_data,
  output logic              o_rsp_crc_err,
  output logic              o_busy,
  output logic              o_spi_sclk,
  output logic              o_spi_csb,
  output logic              o_spi_mosi,
  input  logic              i_spi_miso
);

  localparam int unsigned PayW    = 1 + REG_AW + REG_DW;
  localparam int unsigned FrameW  = PayW + REG_CRC_W;
  localparam int unsigned LastBit = FrameW - 1;
  localparam int unsigned BcW     = $clog2(FrameW);
  localparam int unsigned HcW     = $clog2(SCLK_DIV);
  localparam int unsigned PhW     = 8;
  localparam logic [REG_CRC_W-1:0] CrcPoly = REG_CRC_W'(8'h07);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  // CRC-8 (x^8+x^2+x+1), zero init, MSB first over the payload.
  function automatic logic [REG_CRC_W-1:0] crc16to8_parallel(input logic [PayW-1:0] d);
    logic [REG_CRC_W-1:0] c;
    logic                 fb;
    c = '0;
    for (int i = PayW - 1; i >= 0; i--) begin
      fb = c[REG_CRC_W-1] ^ d[i];
      c  = {c[REG_CRC_W-2:0], 1'b0};
      if (fb) c = c ^ CrcPoly;
    end
    return c;
  endfunction

  state_e              state_q, state_d;
  logic [PhW-1:0]      ph_q, ph_d;
  logic [HcW-1:0]      hcnt_q, hcnt_d;
  logic [BcW-1:0]      bit_q, bit_d;
  logic                high_q, high_d;
  logic [FrameW-1:0]   tx_sr_q, tx_sr_d;
  logic [FrameW-1:0]   rx_sr_q, rx_sr_d;
  logic                csb_q, csb_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic                rsp_vld_q, rsp_vld_d, rsp_flag_q, rsp_flag_d, crc_err_q, crc_err_d;
  logic [REG_AW-1:0]   rsp_addr_q, rsp_addr_d;
  logic [REG_DW-1:0]   rsp_data_q, rsp_data_d;
  logic [PayW-1:0]     tx_pay;
  logic [FrameW-1:0]   rx_full;

  assign o_req_rdy = (state_q == StIdle) & i_spi_mst_en & i_rst_n;
  assign o_busy    = (state_q != StIdle);
  assign tx_pay    = {i_req_wr, i_req_addr, i_req_wr ? i_req_wdata : REG_DW'(0)};
  assign rx_full   = {rx_sr_q[FrameW-2:0], i_spi_miso};

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    hcnt_d     = hcnt_q;
    bit_d      = bit_q;
    high_d     = high_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    csb_d      = csb_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    rsp_vld_d  = 1'b0;
    rsp_flag_d = rsp_flag_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    crc_err_d  = crc_err_q;
    unique case (state_q)
      StIdle: begin
        if (i_req_vld && o_req_rdy) begin
          tx_sr_d = {tx_pay, crc16to8_parallel(tx_pay)};
          mosi_d  = tx_pay[PayW-1];
          csb_d   = 1'b0;
          ph_d    = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (ph_q == PhW'(CS_SETUP - 1)) begin
          state_d = StShift;
          sclk_d  = 1'b1;
          high_d  = 1'b1;
          hcnt_d  = '0;
          bit_d   = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StShift: begin
        if (hcnt_q == HcW'(SCLK_DIV - 1)) begin
          hcnt_d = '0;
          if (high_q) begin
            sclk_d  = 1'b0;
            high_d  = 1'b0;
            mosi_d  = tx_sr_q[LastBit-1];
            tx_sr_d = {tx_sr_q[FrameW-2:0], 1'b0};
          end else if (bit_q == BcW'(LastBit)) begin
            state_d = StHold;
            ph_d    = '0;
          end else begin
            // The slave shifts on the rise, so the end of the low half is the stable point.
            rx_sr_d = rx_full;
            bit_d   = bit_q + 1'b1;
            sclk_d  = 1'b1;
            high_d  = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      StHold: begin
        if (ph_q == PhW'(CS_HOLD - 1)) begin
          rx_sr_d    = rx_full;
          csb_d      = 1'b1;
          rsp_vld_d  = 1'b1;
          rsp_flag_d = rx_full[LastBit];
          rsp_addr_d = rx_full[LastBit-1 -: REG_AW];
          rsp_data_d = rx_full[REG_CRC_W +: REG_DW];
          crc_err_d  = crc16to8_parallel(rx_full[FrameW-1:REG_CRC_W]) !=
                       rx_full[REG_CRC_W-1:0];
          ph_d       = '0;
          state_d    = StGap;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StGap: begin
        if (ph_q == PhW'(GAP_CYC - 1)) state_d = StIdle;
        else ph_d = ph_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      ph_q       <= '0;
      hcnt_q     <= '0;
      bit_q      <= '0;
      high_q     <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      csb_q      <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_flag_q <= 1'b0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      hcnt_q     <= hcnt_d;
      bit_q      <= bit_d;
      high_q     <= high_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      csb_q      <= csb_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_flag_q <= rsp_flag_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
      crc_err_q  <= crc_err_d;
    end
  end

  assign o_spi_csb     = csb_q;
  assign o_spi_sclk    = sclk_q;
  assign o_spi_mosi    = mosi_q;
  assign o_rsp_vld     = rsp_vld_q;
  assign o_rsp_flag    = rsp_flag_q;
  assign o_rsp_addr    = rsp_addr_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_crc_err = crc_err_q;

endmodule

// File: tb/tb_spi_mst.sv
// Directed bench for spi_mst with a behavioural register slave on the SPI pins.
module tb_spi_mst;

  logic       clk = 1'b0;
  logic       rst_n, en, vld, wr, miso;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       rdy, rsp_vld, rsp_flag, rsp_crc_err, busy, sclk, csb, mosi;
  logic [6:0] rsp_addr;
  logic [7:0] rsp_data;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  spi_mst dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_spi_mst_en (en),
    .i_req_vld    (vld),
    .o_req_rdy    (rdy),
    .i_req_wr     (wr),
    .i_req_addr   (addr),
    .i_req_wdata  (wdata),
    .o_rsp_vld    (rsp_vld),
    .o_rsp_flag   (rsp_flag),
    .o_rsp_addr   (rsp_addr),
    .o_rsp_data   (rsp_data),
    .o_rsp_crc_err(rsp_crc_err),
    .o_busy       (busy),
    .o_spi_sclk   (sclk),
    .o_spi_csb    (csb),
    .o_spi_mosi   (mosi),
    .i_spi_miso   (miso)
  );

  // Reference CRC by polynomial long division of {d, 8'h00} by 0x107.
  function automatic logic [7:0] crc_ref(input logic [15:0] d);
    logic [23:0] r;
    r = {d, 8'h00};
    for (int i = 23; i >= 8; i--) if (r[i]) r[i-:9] = r[i-:9] ^ 9'h107;
    return r[7:0];
  endfunction

  // Slave model + monitors, evaluated on the falling clock edge.
  logic [7:0]  regs [128];
  logic [23:0] sl_rsp_next = 24'h0;
  logic [23:0] sl_out, sl_rx, last_frame;
  int          sl_rises, last_rises, low_run, last_low, high_run, gap_min;
  int          rsp_cnt = 0, rdy_viol = 0;
  logic        prev_csb = 1'b1, prev_sclk = 1'b0, corrupt3 = 1'b0;

  initial begin
    for (int a = 0; a < 128; a++) regs[a] = 8'(a) ^ 8'h5A;
    miso = 1'b0;
  end

  always @(negedge clk) begin
    if (rsp_vld) rsp_cnt++;
    if (rdy && busy) rdy_viol++;
    if (prev_csb && !csb) begin
      if (high_run < gap_min) gap_min = high_run;
      sl_out   = sl_rsp_next;
      sl_rises = 0;
      sl_rx    = 24'h0;
      low_run  = 0;
      miso     = sl_out[23];
    end
    if (!csb) begin
      low_run++;
      if (sclk && !prev_sclk) begin
        sl_rx = {sl_rx[22:0], mosi};
        sl_rises++;
        if (sl_rises >= 2 && sl_rises <= 24)
          miso = sl_out[24-sl_rises] ^ (corrupt3 && (24 - sl_rises) == 3);
      end
    end else begin
      high_run++;
    end
    if (!prev_csb && csb) begin
      last_frame = sl_rx;
      last_rises = sl_rises;
      last_low   = low_run;
      high_run   = 1;
      if (sl_rises == 24 && crc_ref(sl_rx[23:8]) == sl_rx[7:0]) begin
        if (sl_rx[23]) begin
          regs[sl_rx[22:16]] = sl_rx[15:8];
          sl_rsp_next[23:8] = {1'b1, sl_rx[22:16], sl_rx[15:8]};
        end else begin
          sl_rsp_next[23:8] = {1'b0, sl_rx[22:16], regs[sl_rx[22:16]]};
        end
        sl_rsp_next[7:0] = crc_ref(sl_rsp_next[23:8]);
      end
    end
    prev_csb  = csb;
    prev_sclk = sclk;
  end

  // Issue one request and wait for its response; returns captured response fields.
  task automatic do_frame(input logic w, input logic [6:0] a, input logic [7:0] d,
                          output logic [23:0] rsp);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy && n < 200) begin @(negedge clk); n++; end
    wr = w; addr = a; wdata = d; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    n = 0;
    while (!rsp_vld && n < 400) begin @(negedge clk); n++; end
    cmp_cnt++;
    if (!rsp_vld) begin
      err_cnt++;
      $display("FAIL rsp_timeout: got rsp_vld=0 expected 1");
    end
    rsp = {rsp_flag, rsp_addr, rsp_data, 7'h0, rsp_crc_err};
    n = 0;
    while (!rdy && n < 100) begin @(negedge clk); n++; end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; vld = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    if ({csb, sclk, mosi, rdy, rsp_vld, busy} !== 6'b100000) begin
      err_cnt++;
      $display("FAIL reset_pins: got %b expected 100000", {csb, sclk, mosi, rdy, rsp_vld, busy});
    end
    cmp_cnt++;
    if ({rsp_flag, rsp_addr, rsp_data, rsp_crc_err} !== 17'h0) begin
      err_cnt++;
      $display("FAIL reset_rsp: got 0x%0h expected 0", {rsp_flag, rsp_addr, rsp_data, rsp_crc_err});
    end
    cmp_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", 32'(rdy), 32'd1);
  endtask

  task automatic test_write();
    logic [23:0] r;
    do_frame(1'b1, 7'h05, 8'h3C, r);
    chk("wr_mosi_frame", 32'(last_frame), {8'h0, 8'h85, 8'h3C, crc_ref(16'h853C)});
    chk("wr_sclk_rises", 32'(last_rises), 32'd24);
    chk("wr_csb_low", 32'(last_low), 32'd100);
    chk("first_rsp_is_slave_reset", 32'(r), 32'h0);
  endtask

  task automatic test_read();
    logic [23:0] r;
    do_frame(1'b0, 7'h12, 8'hFF, r);
    chk("rd_mosi_frame", 32'(last_frame), {8'h0, 8'h12, 8'h00, crc_ref(16'h1200)});
    chk("wr_ack_rsp", 32'(r), {8'h0, 1'b1, 7'h05, 8'h3C, 8'h00});
    do_frame(1'b0, 7'h00, 8'h00, r);
    chk("rd_data_rsp", 32'(r), {8'h0, 1'b0, 7'h12, 8'h48, 8'h00});
  endtask

  task automatic test_crc_err();
    logic [23:0] r;
    corrupt3 = 1'b1;
    do_frame(1'b0, 7'h01, 8'h00, r);
    corrupt3 = 1'b0;
    chk("crc_err_rsp", 32'(r), {8'h0, 1'b0, 7'h00, 8'h5A, 8'h01});
  endtask

  task automatic test_back_to_back();
    int acc, n, base;
    acc = 0; n = 0; base = rsp_cnt; gap_min = 1000; rdy_viol = 0;
    wr = 1'b1;
    while (acc < 3 && n < 1000) begin
      @(negedge clk);
      addr = 7'h20 + 7'(acc); wdata = 8'hA0 + 8'(acc); vld = 1'b1;
      if (rdy) acc++;
      n++;
    end
    @(negedge clk);
    vld = 1'b0;
    n = 0;
    while ((busy || rsp_cnt - base < 3) && n < 400) begin @(negedge clk); n++; end
    chk("b2b_accepts", 32'(acc), 32'd3);
    chk("b2b_rsp_count", 32'(rsp_cnt - base), 32'd3);
    chk("b2b_min_gap", 32'(gap_min >= 16), 32'd1);
    chk("b2b_rdy_while_busy", 32'(rdy_viol), 32'd0);
    chk("b2b_last_write", 32'(regs[7'h22]), 32'hA2);
  endtask

  task automatic test_en_drop();
    int n, base, rdy_seen;
    base = rsp_cnt; n = 0; rdy_seen = 0;
    @(negedge clk);
    wr = 1'b0; addr = 7'h22; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    while (!(sl_rises == 6 && sclk) && n < 200) begin @(negedge clk); n++; end
    en = 1'b0;
    n = 0;
    while (!rsp_vld && n < 300) begin @(negedge clk); n++; end
    chk("en_drop_rsp", 32'({rsp_flag, rsp_addr, rsp_data}), {16'h0, 1'b1, 7'h22, 8'hA2});
    repeat (40) begin
      @(negedge clk);
      if (rdy) rdy_seen++;
    end
    chk("en_drop_rsp_once", 32'(rsp_cnt - base), 32'd1);
    chk("en_drop_idle", 32'(busy), 32'd0);
    chk("en_drop_rdy_low", 32'(rdy_seen), 32'd0);
    en = 1'b1;
    @(negedge clk);
    chk("en_restore_rdy", 32'(rdy), 32'd1);
  endtask

  task automatic test_abort();
    int n, base;
    n = 0;
    @(negedge clk);
    wr = 1'b1; addr = 7'h33; wdata = 8'h77; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    while (!(sl_rises == 11 && sclk) && n < 200) begin @(negedge clk); n++; end
    base = rsp_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_pins", 32'({csb, sclk, busy, rsp_vld}), 32'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_cnt - base), 32'd0);
    chk("abort_no_write", 32'(regs[7'h33]), 32'(8'h33 ^ 8'h5A));
    chk("abort_rdy", 32'(rdy), 32'd1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_crc_err();
    test_back_to_back();
    test_en_drop();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
